// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion scheduler.
package a2d_pkg;
  localparam int A2D_CMD_W = 16;
  localparam int A2D_RES_W = 12;

  localparam logic [2:0] LFT_CHNL_DEF  = 3'd0;
  localparam logic [2:0] RGHT_CHNL_DEF = 3'd4;
  localparam logic [2:0] BATT_CHNL_DEF = 3'd5;
  localparam logic [A2D_RES_W-1:0] BATT_THRES_DEF = 12'h800;
  localparam logic [A2D_RES_W-1:0] BATT_HYST      = 12'h040;

  typedef enum logic [2:0] {IDLE, CMD, WAIT_CMD, GAP, RD, WAIT_RD, NEXT} state_e;
  typedef enum logic [1:0] {SEL_LFT, SEL_RGHT, SEL_BATT} ch_sel_e;

  function automatic logic [A2D_CMD_W-1:0] build_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction
endpackage

// File: rtl/a2d_tmo_cnt.sv
// SPI done timeout counter: cleared on load, counts while enabled, pulses expire on the TMO_CYC-th cycle.
module a2d_tmo_cnt #(
  parameter int TMO_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (load)           cnt <= '0;
    else if (en && !expire)  cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/a2d_sched.sv
// Round scheduler for left/right load cell and battery A2D reads over a shared SPI master.
// Define BATT_HYST_EN to add a hysteresis band to batt_low.
module a2d_sched import a2d_pkg::*; #(
  parameter logic [2:0]           LFT_CHNL   = LFT_CHNL_DEF,
  parameter logic [2:0]           RGHT_CHNL  = RGHT_CHNL_DEF,
  parameter logic [2:0]           BATT_CHNL  = BATT_CHNL_DEF,
  parameter int                   BATT_DIV   = 8,
  parameter logic [A2D_RES_W-1:0] BATT_THRES = BATT_THRES_DEF,
  parameter int                   TMO_CYC    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nxt,
  input  logic                 done,
  input  logic [A2D_CMD_W-1:0] rd_data,
  output logic                 wrt,
  output logic [A2D_CMD_W-1:0] cmd,
  output logic [A2D_RES_W-1:0] lft_ld,
  output logic [A2D_RES_W-1:0] rght_ld,
  output logic [A2D_RES_W-1:0] batt,
  output logic                 batt_low,
  output logic                 rnd_vld,
  output logic                 ovr,
  output logic                 tmo
);
  localparam int DW = (BATT_DIV > 1) ? $clog2(BATT_DIV) : 1;

  state_e        state, nstate;
  ch_sel_e       ch;
  logic [DW-1:0] div_cnt;
  logic [2:0]    chnl;
  logic          pending, start, finish, cap, tmo_hit, expire;
  logic          batt_upd, batt_low_nxt;
  logic          rd_unused;

  assign rd_unused = ^rd_data[A2D_CMD_W-1:A2D_RES_W];

  always_comb begin
    case (ch)
      SEL_LFT:  chnl = LFT_CHNL;
      SEL_RGHT: chnl = RGHT_CHNL;
      default:  chnl = BATT_CHNL;
    endcase
  end

  assign cmd = (state == IDLE) ? '0 : build_cmd(chnl);

  a2d_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wrt),
    .en     ((state == WAIT_CMD) || (state == WAIT_RD)),
    .expire (expire)
  );

  always_comb begin
    nstate  = state;
    wrt     = 1'b0;
    rnd_vld = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;
    cap     = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE:     if (nxt || pending) begin nstate = CMD; start = 1'b1; end
      CMD:      begin wrt = 1'b1; nstate = WAIT_CMD; end
      WAIT_CMD: if (done) nstate = GAP;
                else if (expire) begin nstate = IDLE; tmo_hit = 1'b1; end
      GAP:      nstate = RD;
      RD:       begin wrt = 1'b1; nstate = WAIT_RD; end
      WAIT_RD:  if (done) begin cap = 1'b1; nstate = NEXT; end
                else if (expire) begin nstate = IDLE; tmo_hit = 1'b1; end
      NEXT:     if (ch == SEL_LFT || (ch == SEL_RGHT && div_cnt == '0)) nstate = CMD;
                else begin finish = 1'b1; rnd_vld = 1'b1; nstate = IDLE; end
      default:  nstate = IDLE;
    endcase
  end

`ifdef BATT_HYST_EN
  // Hold batt_low inside [THRES, THRES+HYST) so a noisy battery near threshold doesn't chatter.
  always_comb begin
    if (batt < BATT_THRES)
      batt_low_nxt = 1'b1;
    else if ({1'b0, batt} >= ({1'b0, BATT_THRES} + {1'b0, BATT_HYST}))
      batt_low_nxt = 1'b0;
    else
      batt_low_nxt = batt_low;
  end
`else
  assign batt_low_nxt = (batt < BATT_THRES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= SEL_LFT;
      div_cnt  <= '0;
      pending  <= 1'b0;
      ovr      <= 1'b0;
      tmo      <= 1'b0;
      lft_ld   <= '0;
      rght_ld  <= '0;
      batt     <= '1;
      batt_upd <= 1'b0;
      batt_low <= 1'b0;
    end else begin
      state <= nstate;
      if (start)
        ch <= SEL_LFT;
      else if (state == NEXT && !finish)
        ch <= (ch == SEL_LFT) ? SEL_RGHT : SEL_BATT;
      if (finish)
        div_cnt <= (div_cnt == DW'(BATT_DIV - 1)) ? '0 : div_cnt + DW'(1);
      // One-deep trigger queue; a trigger landing on the start cycle stays queued.
      if (start)
        pending <= pending && nxt;
      else if (nxt) begin
        if (pending) ovr <= 1'b1;
        pending <= 1'b1;
      end
      if (tmo_hit) tmo <= 1'b1;
      if (cap) begin
        case (ch)
          SEL_LFT:  lft_ld  <= rd_data[A2D_RES_W-1:0];
          SEL_RGHT: rght_ld <= rd_data[A2D_RES_W-1:0];
          default:  batt    <= rd_data[A2D_RES_W-1:0];
        endcase
      end
      batt_upd <= cap && (ch == SEL_BATT);
      if (batt_upd) batt_low <= batt_low_nxt;
    end
  end
endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched: randomized SPI latency/data, reference model of round contents.
module tb_a2d_sched;
  localparam int          BATT_DIV = 2;
  localparam int          TMO_CYC  = 64;
  localparam logic [11:0] THR      = 12'h800;

  logic        clk = 1'b0, rst_n = 1'b0, nxt = 1'b0, done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        wrt, batt_low, rnd_vld, ovr, tmo;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;

  always #5 clk = ~clk;

  a2d_sched #(.BATT_DIV(BATT_DIV), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .batt_low(batt_low), .rnd_vld(rnd_vld), .ovr(ovr), .tmo(tmo)
  );

  typedef struct {
    logic [11:0] l, r, b;
    logic        bl_before, bl_after;
  } rnd_t;

  int          checks = 0, errors = 0, cmds_seen = 0, rounds_seen = 0;
  logic [15:0] cq[$];
  rnd_t        rq[$];
  logic [11:0] spi_val[8];
  int          withhold_ch = -1;

  // Reference model: what the spec says a round contains.
  int          round_idx = 0;
  logic [11:0] m_l = '0, m_r = '0, m_batt = 12'hFFF;
  logic        m_bl = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ecmd(input int c);
    logic [2:0] c3;
    c3 = 3'(c);
    return {2'b00, c3, 11'h000};
  endfunction

  function automatic logic bl_rule(input logic [11:0] b, input logic prev);
`ifdef BATT_HYST_EN
    if (b < THR) return 1'b1;
    if (int'(b) >= int'(THR) + 'h40) return 1'b0;
    return prev;
`else
    return b < THR;
`endif
  endfunction

  // SPI slave: random latency, upper result bits filled with junk.
  initial begin
    int lat;
    bit busy, second;
    logic [15:0] pdata;
    busy = 0; second = 0; lat = 0; pdata = '0;
    forever begin
      @(posedge clk); #1;
      done = 1'b0;
      if (!rst_n) begin busy = 0; second = 0; end
      else if (busy) begin
        if (lat == 0) begin done = 1'b1; rd_data = pdata; busy = 0; end
        else lat--;
      end else if (wrt) begin
        spi_val[7] = 12'(int'(cmd[13:11]));
        pdata = second ? {4'hA, spi_val[cmd[13:11]]} : 16'($urandom);
        busy  = !(second && withhold_ch == int'(cmd[13:11]));
        lat   = $urandom_range(0, 4);
        second = !second;
      end
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT issues wrt or rnd_vld.
  initial begin
    logic bl_chk, bl_exp;
    logic [15:0] ec;
    rnd_t er;
    bl_chk = 0; bl_exp = 0;
    forever begin
      @(negedge clk);
      if (bl_chk) begin chk("batt_low_after", batt_low, bl_exp); bl_chk = 0; end
      if (wrt) begin
        cmds_seen++;
        if (cq.size() == 0) chk("unexpected_wrt", cmd, 16'hFFFF);
        else begin ec = cq.pop_front(); chk("cmd", cmd, ec); end
      end
      if (rnd_vld) begin
        rounds_seen++;
        if (rq.size() == 0) chk("unexpected_rnd_vld", 1, 0);
        else begin
          er = rq.pop_front();
          chk("lft_ld", lft_ld, er.l);
          chk("rght_ld", rght_ld, er.r);
          chk("batt", batt, er.b);
          chk("batt_low_before", batt_low, er.bl_before);
          bl_exp = er.bl_after; bl_chk = 1;
        end
      end
    end
  end

  task automatic push_round(input logic [11:0] l, r, b);
    rnd_t e;
    spi_val[0] = l; spi_val[4] = r; spi_val[5] = b;
    repeat (2) cq.push_back(ecmd(0));
    repeat (2) cq.push_back(ecmd(4));
    e.bl_before = m_bl;
    if (round_idx % BATT_DIV == 0) begin
      repeat (2) cq.push_back(ecmd(5));
      m_batt = b;
      m_bl = bl_rule(b, m_bl);
    end
    m_l = l; m_r = r;
    e.l = l; e.r = r; e.b = m_batt; e.bl_after = m_bl;
    rq.push_back(e);
    round_idx++;
  endtask

  task automatic pulse_nxt();
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
  endtask

  task automatic wait_rounds(input int target);
    for (int i = 0; i < 3000 && rounds_seen < target; i++) @(posedge clk);
    if (rounds_seen < target) chk("round_wait_timeout", rounds_seen, target);
  endtask

  task automatic do_round(input logic [11:0] l, r, b);
    int t;
    t = rounds_seen + 1;
    push_round(l, r, b);
    pulse_nxt();
    wait_rounds(t);
    repeat (2) @(posedge clk);
  endtask

  task automatic batt_round(input logic [11:0] b);
    if (round_idx % BATT_DIV != 0)
      do_round(12'($urandom), 12'($urandom), 12'($urandom));
    do_round(12'($urandom), 12'($urandom), b);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lft"}, lft_ld, 12'h000);
    chk({tag, "_rght"}, rght_ld, 12'h000);
    chk({tag, "_batt"}, batt, 12'hFFF);
    chk({tag, "_batt_low"}, batt_low, 1'b0);
    chk({tag, "_wrt"}, wrt, 1'b0);
    chk({tag, "_rnd_vld"}, rnd_vld, 1'b0);
    chk({tag, "_ovr"}, ovr, 1'b0);
    chk({tag, "_tmo"}, tmo, 1'b0);
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [11:0] hv[3];
    logic        hexp[3];
    int          base, t;
    hv = '{12'h7F0, 12'h820, 12'h850};
`ifdef BATT_HYST_EN
    hexp = '{1'b1, 1'b1, 1'b0};
`else
    hexp = '{1'b1, 1'b0, 1'b0};
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_cmd", cmd, 16'h0000);

    do_round(12'h123, 12'h456, 12'h7FF);
    chk("first_batt_low", batt_low, 1'b1);

    repeat (4) do_round(12'($urandom), 12'($urandom), 12'($urandom));

    for (int i = 0; i < 3; i++) begin
      batt_round(hv[i]);
      chk("hyst_batt_low", batt_low, hexp[i]);
    end

    // Back-to-back: second trigger queues a round, third overruns.
    t = rounds_seen + 2;
    push_round(12'h111, 12'h222, 12'h333);
    push_round(12'h111, 12'h222, 12'h333);
    pulse_nxt();
    repeat (3) @(posedge clk);
    pulse_nxt();
    repeat (1) @(posedge clk);
    pulse_nxt();
    @(negedge clk);
    chk("ovr_set", ovr, 1'b1);
    wait_rounds(t);
    repeat (100) @(posedge clk);
    chk("no_extra_rounds", rounds_seen, t);
    chk("cmd_queue_empty_b2b", cq.size(), 0);

    // Timeout on the right-channel read.
    withhold_ch = 4;
    spi_val[0] = 12'hABC; spi_val[4] = 12'hDEF;
    repeat (2) cq.push_back(ecmd(0));
    repeat (2) cq.push_back(ecmd(4));
    base = rounds_seen;
    pulse_nxt();
    for (int i = 0; i < 4 * TMO_CYC + 200 && tmo !== 1'b1; i++) @(posedge clk);
    @(negedge clk);
    chk("tmo_set", tmo, 1'b1);
    chk("tmo_lft_updated", lft_ld, 12'hABC);
    chk("tmo_rght_held", rght_ld, m_r);
    chk("tmo_batt_held", batt, m_batt);
    chk("tmo_no_rnd_vld", rounds_seen, base);
    chk("tmo_cmd_queue_empty", cq.size(), 0);
    m_l = 12'hABC;
    withhold_ch = -1;
    do_round(12'($urandom), 12'($urandom), 12'($urandom));

    // Reset while parked in WAIT_RD of the left channel.
    withhold_ch = 0;
    spi_val[0] = 12'h555;
    repeat (2) cq.push_back(ecmd(0));
    base = cmds_seen;
    pulse_nxt();
    for (int i = 0; i < 200 && cmds_seen < base + 2; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    cq.delete(); rq.delete();
    round_idx = 0; m_batt = 12'hFFF; m_bl = 1'b0; m_l = '0; m_r = '0;
    withhold_ch = -1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_round(12'h0F0, 12'h0E0, 12'h900);
    chk("after_rst_batt_low", batt_low, 1'b0);

    repeat (10) @(posedge clk);
    chk("final_cmd_queue_empty", cq.size(), 0);
    chk("final_rnd_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
